// File: rtl/voice_stamp_queue.sv
// Event timestamp capture queue: stamps each i_mark with the timebase and the interval
// since the previous accepted capture, buffers entries in a small FIFO with a registered head.
module voice_stamp_queue #(
  parameter int WIDTH      = 24,
  parameter int DEPTH_LOG2 = 3,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [WIDTH-1:0]      i_time,
  input  logic                  i_mark,
  input  logic [TAG_W-1:0]      i_tag,
  input  logic                  i_ready,
  input  logic                  i_clr_ovf,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_time,
  output logic [WIDTH-1:0]      o_delta,
  output logic [TAG_W-1:0]      o_tag,
  output logic                  o_first,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow,
  output logic [7:0]            o_drop_cnt
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam int                  ENTRY_W = 1 + TAG_W + 2 * WIDTH;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_LVL  = (DEPTH_LOG2 + 1)'(1);

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    head_reg;
  logic [ENTRY_W-1:0]    new_entry;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic [WIDTH-1:0]      last_time_reg, delta;
  logic                  seen_reg;
  logic                  ovf_reg;
  logic [7:0]            drop_cnt_reg;
  logic                  pop, push, drop, full, bypass;

  assign full  = (level_reg == FULL_LVL);
  assign pop   = (level_reg != '0) & i_ready;
  assign push  = i_mark & (~full | pop);
  assign drop  = i_mark & ~push;
  assign delta = seen_reg ? (i_time - last_time_reg) : '0;
  assign new_entry = {~seen_reg, i_tag, delta, i_time};

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (pop) rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // The entry being written becomes the head only when it lands in an otherwise empty queue.
  assign bypass = push & (level_next == ONE_LVL);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= new_entry;
    head_reg <= bypass ? new_entry : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      last_time_reg <= '0;
      seen_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      if (push) begin
        wr_ptr_reg    <= wr_ptr_reg + 1'b1;
        last_time_reg <= i_time;
        seen_reg      <= 1'b1;
      end
      // A drop wins over a coincident clear, restarting the count at one.
      if (drop) begin
        ovf_reg <= 1'b1;
        if (i_clr_ovf)                 drop_cnt_reg <= 8'd1;
        else if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end else if (i_clr_ovf) begin
        ovf_reg      <= 1'b0;
        drop_cnt_reg <= '0;
      end
    end
  end

  assign o_valid    = (level_reg != '0);
  assign o_level    = level_reg;
  assign o_overflow = ovf_reg;
  assign o_drop_cnt = drop_cnt_reg;
  assign {o_first, o_tag, o_delta, o_time} = head_reg;

endmodule

// File: tb/tb_voice_stamp_queue.sv
// Bench for voice_stamp_queue: directed scenarios plus random traffic against a queue-based model.
module tb_voice_stamp_queue;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [23:0] i_time = '0;
  logic        i_mark = 1'b0;
  logic [3:0]  i_tag = '0;
  logic        i_ready = 1'b0;
  logic        i_clr_ovf = 1'b0;
  logic        o_valid;
  logic [23:0] o_time, o_delta;
  logic [3:0]  o_tag;
  logic        o_first;
  logic [3:0]  o_level;
  logic        o_overflow;
  logic [7:0]  o_drop_cnt;

  voice_stamp_queue dut (
    .clk(clk), .i_rst(i_rst), .i_time(i_time), .i_mark(i_mark), .i_tag(i_tag),
    .i_ready(i_ready), .i_clr_ovf(i_clr_ovf), .o_valid(o_valid), .o_time(o_time),
    .o_delta(o_delta), .o_tag(o_tag), .o_first(o_first), .o_level(o_level),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] t;
    logic [23:0] d;
    logic [3:0]  tag;
    logic        first;
  } ent_t;

  ent_t        q[$];
  logic [23:0] m_last;
  bit          m_seen;
  bit          m_ovf;
  int          m_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("valid", 32'(o_valid), 32'(q.size() != 0));
    check("level", 32'(o_level), 32'(q.size()));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("drop_cnt", 32'(o_drop_cnt), 32'(m_cnt));
    if (q.size() != 0) begin
      check("head_time", 32'(o_time), 32'(q[0].t));
      check("head_delta", 32'(o_delta), 32'(q[0].d));
      check("head_tag", 32'(o_tag), 32'(q[0].tag));
      check("head_first", 32'(o_first), 32'(q[0].first));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_mark = 1'b0; i_ready = 1'b0; i_clr_ovf = 1'b0;
    @(posedge clk);
    q.delete(); m_last = '0; m_seen = 0; m_ovf = 0; m_cnt = 0;
    #1;
    check_all();
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // One clock of stimulus; the model applies the FIFO rules directly on a queue.
  task automatic step(input bit mark, input logic [23:0] t, input logic [3:0] tag,
                      input bit rdy, input bit clr);
    bit   pop, push;
    ent_t e;
    @(negedge clk);
    i_mark = mark; i_time = t; i_tag = tag; i_ready = rdy; i_clr_ovf = clr;
    @(posedge clk);
    pop  = (q.size() > 0) && rdy;
    push = mark && ((q.size() < 8) || pop);
    if (pop) void'(q.pop_front());
    if (push) begin
      e.t     = t;
      e.d     = m_seen ? (t - m_last) : 24'd0;
      e.tag   = tag;
      e.first = !m_seen;
      q.push_back(e);
      m_last = t;
      m_seen = 1;
    end
    if (mark && !push) begin
      m_ovf = 1;
      m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
    #1;
    check_all();
    $display("step mark=%0d t=%06h tag=%0h rdy=%0d clr=%0d -> valid=%0d lvl=%0d ovf=%0d drops=%0d",
             mark, t, tag, rdy, clr, o_valid, o_level, o_overflow, o_drop_cnt);
  endtask

  logic [23:0] tcur;

  initial begin
    m_last = '0; m_seen = 0; m_ovf = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // basic ordering, delta and first flag
    step(1, 24'h000010, 4'd1, 1, 0);
    check("basic_first1", 32'(o_first), 32'd1);
    check("basic_delta1", 32'(o_delta), 32'd0);
    step(1, 24'h000034, 4'd2, 1, 0);
    check("basic_delta2", 32'(o_delta), 32'h24);
    step(0, 24'h000040, 4'd0, 1, 0);
    check("basic_empty", 32'(o_valid), 32'd0);

    // timebase wrap
    do_reset();
    step(1, 24'hFFFFFE, 4'd3, 0, 0);
    step(1, 24'h000003, 4'd4, 1, 0);
    check("wrap_delta", 32'(o_delta), 32'd5);
    step(0, 24'h000004, 4'd0, 1, 0);

    // full and drop
    do_reset();
    for (int k = 0; k < 10; k++) step(1, 24'(k), 4'(k), 0, 0);
    check("full_level", 32'(o_level), 32'd8);
    check("full_ovf", 32'(o_overflow), 32'd1);
    check("full_drops", 32'(o_drop_cnt), 32'd2);
    for (int k = 0; k < 8; k++) begin
      check("drain_time", 32'(o_time), 32'(k));
      step(0, 24'd0, 4'd0, 1, 0);
    end
    step(1, 24'd20, 4'd9, 0, 0);
    check("span_delta", 32'(o_delta), 32'd13);

    // full with simultaneous push and pop, then saturation and clear
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 24'(100 + k), 4'(k), 0, 0);
    step(1, 24'd200, 4'd5, 1, 0);
    check("pushpop_level", 32'(o_level), 32'd8);
    check("pushpop_drops", 32'(o_drop_cnt), 32'd0);
    check("pushpop_head", 32'(o_time), 32'd101);
    for (int k = 0; k < 300; k++) step(1, 24'(300 + k), 4'd6, 0, 0);
    check("sat_drops", 32'(o_drop_cnt), 32'd255);
    step(0, 24'd0, 4'd0, 0, 1);
    check("clr_ovf", 32'(o_overflow), 32'd0);
    check("clr_drops", 32'(o_drop_cnt), 32'd0);
    step(1, 24'd999, 4'd0, 0, 1);
    check("clr_drop_ovf", 32'(o_overflow), 32'd1);
    check("clr_drop_cnt", 32'(o_drop_cnt), 32'd1);

    // reset mid-stream
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 24'(50 + k * 3), 4'(k), 0, 0);
    do_reset();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    step(1, 24'h000055, 4'd7, 0, 0);
    check("rst_first", 32'(o_first), 32'd1);
    check("rst_delta", 32'(o_delta), 32'd0);

    // random traffic with phases biased toward full and toward empty
    tcur = 24'hFFFF00;
    for (int i = 0; i < 3000; i++) begin
      tcur = tcur + 24'($urandom_range(1, 60));
      if ($urandom_range(0, 499) == 0) tcur = 24'hFFFFF0;
      if ($urandom_range(0, 999) == 0) do_reset();
      else step($urandom_range(0, 99) < 55, tcur, 4'($urandom),
                $urandom_range(0, 99) < (((i / 200) % 2 == 0) ? 30 : 80),
                $urandom_range(0, 99) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/voice_stamp_queue.md
# voice_stamp_queue

Event timestamp capture queue for the voice path. Samples the free-running 24-bit timebase count on each event strobe, computes the interval since the previous captured event, and buffers {time, delta, tag, first} in a small FIFO. The consumer (packetizer or CPU-side reader) drains the FIFO through a valid/ready handshake. Drops on full are counted, never silent.

## Interface
Parameters:
- WIDTH, 24, timebase width; equals the width of the upstream counter output.
- DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 entries (default 8).
- TAG_W, 4, event tag width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_time  in  WIDTH  timebase count; connects to the counter `q` output.
- i_mark  in  1  capture strobe; one capture request per high cycle.
- i_tag  in  TAG_W  event identifier, sampled with i_mark.
- i_ready  in  1  consumer accepts head entry.
- i_clr_ovf  in  1  clears o_overflow and o_drop_cnt.
- o_valid  out  1  head entry present.
- o_time  out  WIDTH  head entry timestamp.
- o_delta  out  WIDTH  head entry interval, (time - previous accepted time) mod 2**WIDTH.
- o_tag  out  TAG_W  head entry tag.
- o_first  out  1  head entry is the first accepted capture since reset.
- o_level  out  DEPTH_LOG2+1  occupancy, 0..2**DEPTH_LOG2.
- o_overflow  out  1  sticky: at least one capture dropped.
- o_drop_cnt  out  8  dropped captures, saturating at 255.

## Operation
- Storage: circular buffer, write pointer, read pointer, occupancy counter (DEPTH_LOG2+1 bits). Entry = {first, tag, delta, time}.
- Push request = i_mark. Pop = o_valid & i_ready.
- Push accepted when level < DEPTH, or level == DEPTH with a pop in the same cycle.
- Accepted push: time = i_time at that edge; delta = i_time - last_time (WIDTH-bit wrap subtraction); first = ~seen. Then last_time <= i_time and seen <= 1.
- First accepted capture after reset: first=1, delta=0.
- Rejected push (full, no pop): entry discarded; last_time and seen unchanged, so the next accepted delta spans the dropped event. o_overflow <= 1; o_drop_cnt increments, saturating at 255.
- i_clr_ovf: o_overflow <= 0 and o_drop_cnt <= 0. A drop in the same cycle has priority: o_overflow=1, o_drop_cnt=1.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- A pop with o_valid=0 is ignored. A push to an empty FIFO is never bypassed combinationally.
- Wrap-around: both pointers wrap mod DEPTH. A timebase wrap yields the correct modular delta, e.g. FFFFFE -> 000003 gives delta 5.

## Timing
- Reset (i_rst high at an edge): pointers, level, last_time, seen, o_overflow and o_drop_cnt all clear to 0. o_valid=0, o_level=0, o_drop_cnt=0, o_overflow=0. Head data outputs are don't-care while o_valid=0.
- Reset mid-operation discards all stored entries. The next capture is first=1.
- Capture latency: i_mark at edge N writes the entry at edge N. If the FIFO was empty, o_valid=1 with that entry from cycle N+1, through a registered head.
- Head outputs stay stable while o_valid=1 and i_ready=0.
- A pop at edge N presents the next entry, or o_valid=0, from cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- o_level, o_overflow and o_drop_cnt are registered and reflect the edge just taken.

## Test plan
- Basic: after reset, mark at i_time=0x000010 (tag 1), then at 0x000034 (tag 2), i_ready=1. Required: two entries in order, time 0x10/0x34, delta 0/0x24, first 1/0, tag 1/2. o_valid drops after the second pop.
- Wrap: marks at i_time=0xFFFFFE then 0x000003. Required: second entry delta=0x000005.
- Full/drop: i_ready=0, 10 consecutive marks with i_time=k for k=0..9. Required: level=8, o_overflow=1, o_drop_cnt=2. Draining yields times 0..7. A later mark at 20 gives delta=13.
- Full with simultaneous push+pop: at level=8, assert i_mark and i_ready together. Required: no drop, level stays 8, order preserved.
- Saturation and clear: 300 drops give o_drop_cnt=255. i_clr_ovf alone clears both to 0. i_clr_ovf coincident with a drop gives o_overflow=1, o_drop_cnt=1.
- Reset mid-stream: with 5 entries queued, pulse i_rst for 1 cycle. Required: o_valid=0, o_level=0 next cycle. The next mark yields first=1, delta=0.
